// File: rtl/polyshift_pipe_if.sv
// rtl/polyshift_pipe_if.sv - operand/result handshake bundle for polyshift_pipe
interface polyshift_pipe_if #(
    parameter int WORD_WIDTH = 32
);
    localparam int STAGES = $clog2(WORD_WIDTH);

    // Operand side
    logic                    valid_i;
    logic                    ready_o;
    logic [WORD_WIDTH-1:0]   d_i;
    logic [WORD_WIDTH-2:0]   c_i;
    logic [STAGES-1:0]       shift_size_i;
    logic [1:0]              shift_type_i;
    logic                    shift_left_i;
    logic                    flush_i;

    // Result side
    logic                    valid_o;
    logic                    ready_i;
    logic [WORD_WIDTH-1:0]   d_o;
    logic                    busy_o;

    modport master (
        output valid_i, d_i, c_i, shift_size_i, shift_type_i, shift_left_i, flush_i, ready_i,
        input  ready_o, valid_o, d_o, busy_o
    );

    modport slave (
        input  valid_i, d_i, c_i, shift_size_i, shift_type_i, shift_left_i, flush_i, ready_i,
        output ready_o, valid_o, d_o, busy_o
    );
endinterface

// File: rtl/polyshift_pipe.sv
// rtl/polyshift_pipe.sv - pipelined bidirectional logic/arith/rcr/ror shifter
module polyshift_pipe #(
    parameter int WORD_WIDTH = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    polyshift_pipe_if.slave    bus
);
    localparam int W      = WORD_WIDTH;
    localparam int EW     = 2 * WORD_WIDTH;
    localparam int STAGES = $clog2(WORD_WIDTH);
    localparam int LAST   = STAGES - 1;

    localparam logic [1:0] SH_LOGIC = 2'd0;
    localparam logic [1:0] SH_ARITH = 2'd1;
    localparam logic [1:0] SH_RCR   = 2'd2;
    localparam logic [1:0] SH_ROR   = 2'd3;

    logic [EW-1:0]     e_entry;
    logic [STAGES-1:0] vld_all;
    logic [STAGES-1:0] adv;

    // Widen the operand so every mode becomes a plain zero-fill shift of E
    always_comb begin
        e_entry = '0;
        if (bus.shift_left_i) begin
            case (bus.shift_type_i)
                SH_RCR:  e_entry = {bus.d_i, bus.c_i, 1'b0};
                SH_ROR:  e_entry = {bus.d_i, bus.d_i};
                default: e_entry = {bus.d_i, {W{1'b0}}};
            endcase
        end else begin
            case (bus.shift_type_i)
                SH_LOGIC: e_entry = {{W{1'b0}}, bus.d_i};
                SH_ARITH: e_entry = {{W{bus.d_i[W-1]}}, bus.d_i};
                SH_RCR:   e_entry = {1'b0, bus.c_i, bus.d_i};
                default:  e_entry = {bus.d_i, bus.d_i};
            endcase
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [EW-1:0]     e_in;
        logic [STAGES-1:0] sz_in;
        logic              left_in;
        logic              vld_in;
        logic [EW-1:0]     e_d;
        logic [EW-1:0]     e_q;
        logic              left_q;
        logic              vld_q;

        if (k == 0) begin : g_src
            assign e_in    = e_entry;
            assign sz_in   = bus.shift_size_i;
            assign left_in = bus.shift_left_i;
            assign vld_in  = bus.valid_i;
        end else begin : g_src
            assign e_in    = g_stage[k-1].e_q;
            assign sz_in   = g_stage[k-1].g_sz.sz_q;
            assign left_in = g_stage[k-1].left_q;
            assign vld_in  = g_stage[k-1].vld_q;
        end

        // Size bits are consumed LSB-first; bit 0 of sz_in is this stage's 2^k step
        assign e_d = sz_in[0] ? (left_in ? (e_in << (2 ** k)) : (e_in >> (2 ** k))) : e_in;

        // A stage may move when it or any later stage has a hole, or the sink takes data
        assign adv[k]     = bus.ready_i | ~(&vld_all[LAST:k]);
        assign vld_all[k] = vld_q;

        // Stage valid: flush clears regardless of stall, otherwise follows upstream on advance
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                vld_q <= 1'b0;
            end else if (bus.flush_i) begin
                vld_q <= 1'b0;
            end else if (adv[k]) begin
                vld_q <= vld_in;
            end
        end

        // Stage payload: loaded on advance, held while stalled
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                e_q    <= '0;
                left_q <= 1'b0;
            end else if (adv[k]) begin
                e_q    <= e_d;
                left_q <= left_in;
            end
        end

        if (k < LAST) begin : g_sz
            logic [STAGES-1:0] sz_q;

            // Remaining size bits, realigned so the next stage reads its bit at index 0
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    sz_q <= '0;
                end else if (adv[k]) begin
                    sz_q <= sz_in >> 1;
                end
            end
        end
    end

    assign bus.ready_o = adv[0] & ~bus.flush_i;
    assign bus.valid_o = vld_all[LAST];
    assign bus.busy_o  = |vld_all;
    assign bus.d_o     = g_stage[LAST].left_q ? g_stage[LAST].e_q[EW-1:W]
                                              : g_stage[LAST].e_q[W-1:0];
endmodule

// File: tb/tb_polyshift_pipe.sv
// tb/tb_polyshift_pipe.sv - table and scoreboard bench for polyshift_pipe
module tb_polyshift_pipe;
    localparam int W = 8;
    localparam int S = 3;

    typedef struct {
        logic [W-1:0] d;
        logic [W-2:0] c;
        logic [S-1:0] sz;
        logic [1:0]   ty;
        logic         lf;
        logic [W-1:0] exp;
    } vec_t;

    typedef struct {
        logic [W-1:0] data;
        int           acc_cyc;
    } sb_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    polyshift_pipe_if #(.WORD_WIDTH(W)) bus();

    polyshift_pipe #(.WORD_WIDTH(W)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    sb_t  q[$];
    sb_t  mon_e;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   lat_chk = 1'b0;
    bit   rand_rdy = 1'b0;

    vec_t tbl[16];
    vec_t bp[5];
    vec_t v;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic [W-2:0] c,
                                           input int s, input logic [1:0] ty, input logic lf);
        logic [W-1:0] r;
        int j;
        r = '0;
        for (int i = 0; i < W; i++) begin
            if (!lf) begin
                j = i + s;
                case (ty)
                    2'd0:    r[i] = (j < W) ? d[j] : 1'b0;
                    2'd1:    r[i] = (j < W) ? d[j] : d[W-1];
                    2'd2:    r[i] = (j < W) ? d[j] : ((j - W < W - 1) ? c[j-W] : 1'b0);
                    default: r[i] = d[j % W];
                endcase
            end else begin
                j = i - s;
                case (ty)
                    2'd2:    r[i] = (j >= 0) ? d[j] : c[W-1+j];
                    2'd3:    r[i] = d[(j + W) % W];
                    default: r[i] = (j >= 0) ? d[j] : 1'b0;
                endcase
            end
        end
        return r;
    endfunction

    function automatic vec_t rand_vec(input int sz, input logic [1:0] ty, input logic lf);
        vec_t r;
        r.d   = W'($urandom);
        r.c   = (W-1)'($urandom);
        r.sz  = S'(sz);
        r.ty  = ty;
        r.lf  = lf;
        r.exp = model(r.d, r.c, sz, ty, lf);
        return r;
    endfunction

    // Result monitor: every output handshake must match the oldest pending result
    always @(negedge clk) begin
        if (rst_n && bus.valid_o && bus.ready_i) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got d_o=%0h expected no result pending", bus.d_o);
            end else begin
                mon_e = q.pop_front();
                chk("d_o", {24'd0, bus.d_o}, {24'd0, mon_e.data});
                if (lat_chk) chk("latency", cyc - mon_e.acc_cyc, S);
            end
        end
    end

    task automatic set_ops(input vec_t x);
        bus.d_i          = x.d;
        bus.c_i          = x.c;
        bus.shift_size_i = x.sz;
        bus.shift_type_i = x.ty;
        bus.shift_left_i = x.lf;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) bus.ready_i = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input vec_t x, input bit push);
        bit done;
        int guard;
        done = 1'b0;
        guard = 0;
        bus.valid_i = 1'b1;
        set_ops(x);
        while (!done) begin
            @(negedge clk);
            if (bus.ready_o) begin
                if (push) q.push_back('{x.exp, cyc});
                done = 1'b1;
            end
            tick();
            guard++;
            if (!done && guard > 200) begin
                tests++;
                fails++;
                $display("FAIL send_timeout: got no accept expected accept within 200 cycles");
                done = 1'b1;
            end
        end
        bus.valid_i = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((q.size() != 0 || bus.busy_o) && guard < 400) begin
            tick();
            guard++;
        end
        chk("drain_pending", q.size(), 0);
        chk("drain_busy", bus.busy_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int g;
        int seen;
        logic [W-1:0] held;

        bus.valid_i = 0; bus.d_i = 0; bus.c_i = 0; bus.shift_size_i = 0;
        bus.shift_type_i = 0; bus.shift_left_i = 0; bus.flush_i = 0; bus.ready_i = 1;

        tbl[0] = '{8'b1011_0110, 7'b101_0011, 3'd3, 2'd0, 1'b0, 8'b0001_0110};
        tbl[1] = '{8'b1011_0110, 7'b101_0011, 3'd3, 2'd1, 1'b0, 8'b1111_0110};
        tbl[2] = '{8'b1011_0110, 7'b101_0011, 3'd3, 2'd2, 1'b0, 8'b0111_0110};
        tbl[3] = '{8'b1011_0110, 7'b101_0011, 3'd3, 2'd3, 1'b0, 8'b1101_0110};
        tbl[4] = '{8'b1011_0110, 7'b101_0011, 3'd3, 2'd0, 1'b1, 8'b1011_0000};
        tbl[5] = '{8'b1011_0110, 7'b101_0011, 3'd3, 2'd1, 1'b1, 8'b1011_0000};
        tbl[6] = '{8'b1011_0110, 7'b101_0011, 3'd3, 2'd2, 1'b1, 8'b1011_0101};
        tbl[7] = '{8'b1011_0110, 7'b101_0011, 3'd3, 2'd3, 1'b1, 8'b1011_0101};
        for (int t = 0; t < 4; t++) begin
            for (int l = 0; l < 2; l++) begin
                tbl[8 + t*2 + l] = '{8'b1011_0110, 7'b101_0011, 3'd0, 2'(t), 1'(l), 8'b1011_0110};
            end
        end

        // Reset values
        #1;
        chk("rst_valid_o", bus.valid_o, 0);
        chk("rst_busy_o", bus.busy_o, 0);
        chk("rst_d_o", bus.d_o, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_ready_o", bus.ready_o, 1);
        tick();

        // Directed vectors, back-to-back with latency check
        lat_chk = 1'b1;
        for (int i = 0; i < 16; i++) send(tbl[i], 1'b1);
        drain();
        lat_chk = 1'b0;

        // Backpressure: five offered, three fit, output held
        for (int i = 0; i < 5; i++) bp[i] = rand_vec(i % 8, 2'(i % 4), 1'(i % 2));
        bus.ready_i = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            bus.valid_i = 1'b1;
            set_ops(bp[acc]);
            @(negedge clk);
            if (bus.ready_o && acc < 5) begin
                q.push_back('{bp[acc].exp, cyc});
                acc++;
            end
            tick();
        end
        bus.valid_i = 1'b0;
        chk("bp_accepts", acc, 3);
        chk("bp_ready_low", bus.ready_o, 0);
        @(negedge clk);
        held = bus.d_o;
        chk("bp_valid_o", bus.valid_o, 1);
        repeat (3) @(negedge clk);
        chk("bp_hold", {24'd0, bus.d_o}, {24'd0, held});
        chk("bp_head", {24'd0, bus.d_o}, {24'd0, bp[0].exp});
        tick();
        bus.ready_i = 1'b1;
        send(bp[3], 1'b1);
        send(bp[4], 1'b1);
        drain();

        // Flush with three in flight under backpressure
        bus.ready_i = 1'b0;
        for (int i = 0; i < 3; i++) send(rand_vec(i + 1, 2'(i), 1'b0), 1'b0);
        bus.flush_i = 1'b1;
        bus.valid_i = 1'b1;
        set_ops(rand_vec(5, 2'd3, 1'b1));
        @(negedge clk);
        chk("flush_ready_o", bus.ready_o, 0);
        tick();
        bus.flush_i = 1'b0;
        bus.valid_i = 1'b0;
        chk("flush_valid_o", bus.valid_o, 0);
        chk("flush_busy_o", bus.busy_o, 0);
        bus.ready_i = 1'b1;
        lat_chk = 1'b1;
        send(rand_vec(6, 2'd1, 1'b0), 1'b1);
        drain();
        lat_chk = 1'b0;

        // Flush coinciding with an output handshake: that result still delivers
        send(rand_vec(2, 2'd2, 1'b1), 1'b1);
        g = 0;
        while (!bus.valid_o && g < 20) begin
            tick();
            g++;
        end
        chk("fr_valid_o", bus.valid_o, 1);
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        chk("fr_after_valid", bus.valid_o, 0);
        chk("fr_delivered", q.size(), 0);

        // Exhaustive type x direction x size sweep, throughput then random ready
        for (int m = 0; m < 2; m++) begin
            rand_rdy = 1'(m);
            lat_chk  = (m == 0);
            for (int t = 0; t < 4; t++)
                for (int l = 0; l < 2; l++)
                    for (int s = 0; s < 8; s++) begin
                        v = rand_vec(s, 2'(t), 1'(l));
                        send(v, 1'b1);
                    end
            drain();
            rand_rdy = 1'b0;
            lat_chk  = 1'b0;
            bus.ready_i = 1'b1;
            tick();
        end

        // Reset while two operations are in flight
        send(rand_vec(1, 2'd0, 1'b0), 1'b0);
        send(rand_vec(2, 2'd3, 1'b1), 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid_o", bus.valid_o, 0);
        chk("midrst_busy_o", bus.busy_o, 0);
        chk("midrst_d_o", bus.d_o, 0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_ready_o", bus.ready_o, 1);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.valid_o) seen++;
        end
        chk("midrst_no_stale", seen, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/polyshift_pipe.md
Name: polyshift_pipe

Overview:
- Pipelined, bidirectional successor to polyshift_r.
- Supports all four SHIFT_TYPE modes (LOGIC, ARITH, RCR, ROR) in both directions; in the left direction ROR acts as rotate-left and RCR as rotate-left through the C word.
- One register stage per shift-size bit, with valid/ready flow control and synchronous flush.
- Sits between the ALU operand path and the writeback register; lets the shifter close timing at full clock rate for wide words.

Parameters:
- WORD_WIDTH, 32: data width. Must be a power of two, >= 4.
- STAGES, $clog2(WORD_WIDTH) (derived localparam, not overridable): pipeline depth and latency.

Ports:
- clk_i  input  1  clock; rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- valid_i  input  1  input operation valid.
- ready_o  output  1  block can accept an operation this cycle.
- d_i  input  WORD_WIDTH  data word.
- c_i  input  WORD_WIDTH-1  double-precision/carry word; used only by RCR.
- shift_size_i  input  STAGES  shift amount, 0..WORD_WIDTH-1.
- shift_type_i  input  SHIFT_TYPE  LOGIC=0, ARITH=1, RCR=2, ROR=3.
- shift_left_i  input  1  0 = right, 1 = left.
- flush_i  input  1  synchronous flush of all in-flight operations.
- valid_o  output  1  result valid.
- ready_i  input  1  downstream accepts result.
- d_o  output  WORD_WIDTH  shifted result.
- busy_o  output  1  OR of all stage valid bits.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous, active-low.
- Reset values: all stage valid bits, valid_o, busy_o and d_o are 0. ready_o reads 1 as soon as reset is released.
- Entry expansion (combinational, before stage 0), building a 2W-bit vector E:
  - right LOGIC: {W'0, d}
  - right ARITH: {W{d[W-1]}, d}
  - right RCR: {1'b0, c, d}
  - right ROR: {d, d}
  - left LOGIC/ARITH: {d, W'0}
  - left RCR: {d, c, 1'b0}
  - left ROR: {d, d}
- Left ARITH is identical to left LOGIC.
- Stage k (k = 0..STAGES-1):
  - If size bit k is set, shift E by 2^k: right with zero fill, or left with zero fill.
  - Register E, the remaining size bits, direction and valid.
- Output select: d_o = E[W-1:0] for right shifts, E[2W-1:W] for left shifts, taken from the last stage register.
- A size of 0 returns d_i unchanged in every mode.
- Latency: exactly STAGES cycles from the accepting edge (valid_i & ready_o) to valid_o, when there is no backpressure. Throughput is one operation per cycle.
- Flow control:
  - Stage k advances when it is empty or stage k+1 advances. The last stage advances when valid_o is 0 or ready_i is 1.
  - ready_o = advance condition of stage 0. It is combinational from ready_i through the chain, with no bubbles.
  - A stalled stage holds all fields. d_o stays stable while valid_o=1 and ready_i=0.
  - Up to STAGES operations can be in flight. Order is strictly preserved.
- Flush:
  - flush_i=1 clears every valid bit at the next edge and drops any input presented that cycle; ready_o is forced 0 during flush.
  - Data registers are not cleared; d_o is don't-care while valid_o=0.
- Reset mid-operation: all in-flight operations are lost immediately (asynchronous). No output appears after release.
- Simultaneous flush_i and ready_i: the flush wins, and the output handshake that cycle still completes.
- Shift amounts ≥ WORD_WIDTH cannot be encoded; the width of shift_size_i is exactly STAGES.

Test Plan (W=8, STAGES=3):
- Reset: assert rst_ni=0 mid-stream -> valid_o=0, busy_o=0, d_o=0 immediately. After release -> ready_o=1 and no stale outputs.
- Right shifts of d=8'b1011_0110, size 3, one per cycle:
  - LOGIC -> 8'b0001_0110
  - ARITH -> 8'b1111_0110
  - RCR with c=7'b101_0011 -> 8'b0111_0110
  - ROR -> 8'b1101_0110
  - Each result appears exactly 3 cycles after acceptance, back-to-back.
- Left shifts of d=8'b1011_0110, size 3:
  - LOGIC -> 8'b1011_0000
  - ROR -> 8'b1011_0101
  - RCR with c=7'b101_0011 -> 8'b1011_0101
  - Size 0 in every type/direction -> 8'b1011_0110.
- Backpressure: hold ready_i=0 and present 5 operations -> ready_o falls after 3 accepts and d_o is held stable. Then ready_i=1 -> results arrive in issue order, one per cycle, none lost or duplicated.
- Flush: 3 operations in flight, pulse flush_i for 1 cycle -> valid_o and busy_o are 0 next cycle and the flushed results never appear. An operation issued the following cycle completes normally after 3 cycles.
- Exhaustive sweep: every type × direction × size 0..7 for random d/c, checked against a reference model, in throughput mode and with random ready_i.
